// File: rtl/sgdmac_pkg.sv
// Shared constants and types for the SGDMAC descriptor memory responder.
// Holds the AXI response/burst encodings, the only supported beat size,
// the descriptor length in words and the responder FSM state type.
package sgdmac_pkg;

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI burst types understood by the responder
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Only 32-bit beats are served
  localparam logic [2:0] SIZE_4B = 3'b010;

  // A descriptor is fetched as one 4-beat burst
  localparam int DESC_WORDS = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DATA = 2'd2
  } resp_state_e;

  // FIXED and INCR are served; WRAP and the reserved code are errors
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/sgdmac_desc_ram.sv
// 1R1W synchronous descriptor RAM. Read data is registered and only
// updates when rd_en_i is high, so a presented word stays put while the
// reader stalls. A write to the address being read in the same cycle is
// forwarded to the read register (write-first). Replace this module to
// map onto a vendor SRAM macro.
module sgdmac_desc_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  // Storage array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read with same-cycle write forwarding
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        r_rd_data <= wr_data_i;
      end else begin
        r_rd_data <= r_mem[rd_addr_i];
      end
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/sgdmac_desc_mem_responder.sv
// AXI3-style read-only responder in front of the descriptor RAM.
// One burst at a time: AR handshake -> LOAD (RAM read of first word)
// -> DATA (beats streamed with read-ahead, no bubbles) -> IDLE.
//
// Handshake rules: a transfer happens on a rising clock edge where both
// valid and ready are high. arready_o is only high in IDLE. Once
// rvalid_o is high it, rid_o, rdata_o, rresp_o and rlast_o hold their
// values until the cycle rready_i is sampled high.
//
// Bad requests (outside the window, unaligned, wrong size, unsupported
// burst) still return arlen+1 beats, each with SLVERR and zero data.
// The preload write port is independent of the FSM and never stalls.
module sgdmac_desc_mem_responder
  import sgdmac_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // AR channel
  input  logic [3:0]            arid_i,
  input  logic [31:0]           araddr_i,
  input  logic [3:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  // R channel
  output logic [3:0]            rid_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  // Preload write port
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  // Status / debug
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  // Address bits above the word index that must match the window base
  localparam int TAG_LSB = DEPTH_LOG2 + 2;

  resp_state_e           r_state;
  resp_state_e           w_state_nxt;

  // Burst context latched at the AR handshake
  logic [3:0]            r_id;
  logic [DEPTH_LOG2-1:0] r_idx;    // index of the word currently presented
  logic [3:0]            r_cnt;    // beats remaining after the current one
  logic [1:0]            r_burst;
  logic                  r_err;

  // Registered channel controls
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_ar_err;
  logic                  w_beat_adv;
  logic                  w_arready_nxt;
  logic                  w_rvalid_nxt;
  logic                  w_rlast_nxt;
  logic                  w_rd_en;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [DEPTH_LOG2-1:0] w_next_idx;
  logic [31:0]           w_ram_q;

  assign w_ar_hs = arvalid_i && r_arready;
  assign w_r_hs  = r_rvalid && rready_i;

  // Request is judged once, at the AR handshake
  assign w_ar_err = (araddr_i[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]) ||
                    (araddr_i[1:0] != 2'b00) ||
                    (arsize_i != SIZE_4B) ||
                    !burst_supported(arburst_i);

  // INCR walks the window modulo its size; FIXED rereads the same word
  assign w_next_idx = (r_burst == BURST_FIXED) ? r_idx
                                               : r_idx + DEPTH_LOG2'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ar_hs) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_DATA;
      ST_DATA: if (w_r_hs && r_rlast) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next-cycle channel controls and the RAM read request.
  // The RAM is read in LOAD for the first beat and on every non-final
  // R handshake for the following beat, so beats stream without gaps.
  always_comb begin
    w_arready_nxt = (w_state_nxt == ST_IDLE);
    w_rvalid_nxt  = 1'b0;
    w_rlast_nxt   = 1'b0;
    w_rd_en       = 1'b0;
    w_rd_addr     = r_idx;
    w_beat_adv    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_rd_en      = 1'b1;
        w_rvalid_nxt = 1'b1;
        w_rlast_nxt  = (r_cnt == 4'd0);
      end
      ST_DATA: begin
        w_rvalid_nxt = 1'b1;
        w_rlast_nxt  = r_rlast;
        if (w_r_hs) begin
          if (r_rlast) begin
            w_rvalid_nxt = 1'b0;
            w_rlast_nxt  = 1'b0;
          end else begin
            w_beat_adv  = 1'b1;
            w_rd_en     = 1'b1;
            w_rd_addr   = w_next_idx;
            w_rlast_nxt = (r_cnt == 4'd1);
          end
        end
      end
      default: ;
    endcase
  end

  // Channel control registers; arready drops in reset and returns the
  // cycle after the FSM is back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
    end
  end

  // Burst context: capture on AR, step index/count on each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_INCR;
      r_err   <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= arid_i;
      r_idx   <= araddr_i[TAG_LSB-1:2];
      r_cnt   <= arlen_i;
      r_burst <= arburst_i;
      r_err   <= w_ar_err;
    end else if (w_beat_adv) begin
      r_cnt   <= r_cnt - 4'd1;
      r_idx   <= w_next_idx;
    end
  end

  sgdmac_desc_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (w_rd_en),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_ram_q)
  );

  assign arready_o   = r_arready;
  assign rvalid_o    = r_rvalid;
  assign rlast_o     = r_rlast;
  assign rid_o       = r_id;
  // Data and response are qualified by rvalid so reset shows zeros and
  // error bursts never leak RAM contents
  assign rresp_o     = (r_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rdata_o     = (r_rvalid && !r_err) ? w_ram_q : 32'h0;
  assign busy_o      = (r_state != ST_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: doc/sgdmac_desc_mem_responder.md
Name: sgdmac_desc_mem_responder

Overview:
- AXI3-style read-only responder (AR/R channels) backed by an on-chip descriptor RAM.
- It is the target that the SGDMAC descriptor fetcher issues 4-beat INCR bursts to. It returns descriptor words {next_ptr, ..., addr, len/rw} in address order.
- A simple single-cycle write port lets the CPU/APB side preload descriptor chains.
- It sits between the SGDMAC fetch master and the descriptor SRAM region.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words = 1 KiB window).
- BASE_ADDR, 32'h0000_0000, byte base of the window; must be aligned to 4<<DEPTH_LOG2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arid_i  in  4  read ID
- araddr_i  in  32  byte address
- arlen_i  in  4  beats-1
- arsize_i  in  3  must be 3'b010
- arburst_i  in  2  00 FIXED, 01 INCR, others unsupported
- arvalid_i  in  1  address valid
- arready_o  out  1  address ready
- rid_o  out  4  echoed arid
- rdata_o  out  32  read data
- rresp_o  out  2  00 OKAY, 10 SLVERR
- rlast_o  out  1  final beat
- rvalid_o  out  1  data valid
- rready_i  in  1  data ready
- wr_en_i  in  1  preload write strobe
- wr_addr_i  in  DEPTH_LOG2  word index
- wr_data_i  in  32  preload data
- busy_o  out  1  burst in progress

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, arready_o=0, rvalid_o=0, rlast_o=0, rid_o=0, rdata_o=0, rresp_o=0, busy_o=0. RAM contents are not reset.
- FSM states:
  - IDLE: arready_o=1. AR handshake latches id, word index, remaining count=arlen, burst type, err flag → LOAD.
  - LOAD: no R beat this cycle. RAM read of the current index → DATA with rvalid_o=1 next cycle. Gives first-beat latency of 2 cycles after the AR handshake.
  - DATA: rvalid_o held until rready_i.
    - On a handshake with count!=0: decrement count, advance index, present the next word on the following cycle with no bubble. rdata_o is registered from RAM read-ahead.
    - On a handshake with rlast_o=1: → IDLE. arready_o rises the cycle after.
- Only one outstanding burst. arready_o=0 in LOAD/DATA. busy_o = (state != IDLE).
- rlast_o=1 exactly on beat arlen+1. rvalid, rdata, rresp, rlast and rid are stable while rvalid && !rready.
- Index arithmetic:
  - INCR: index+1 modulo 2^DEPTH_LOG2, wrapping within the window.
  - FIXED: index unchanged.
- Error (err flag), evaluated once at AR handshake:
  - araddr_i[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2], or
  - araddr_i[1:0] != 0, or
  - arsize_i != 3'b010, or
  - arburst_i in {10, 11}.
- With err set, all arlen+1 beats are still returned with rresp_o=2'b10 and rdata_o=0. rlast_o is on the final beat as normal.
- Write port:
  - wr_en_i is accepted every cycle in every state and is never stalled.
  - A write to the index being read-ahead in the same cycle: the read returns the new data (write-first bypass).
  - Already-presented rdata_o is not modified.
- Ordering: rid_o equals the latched arid for every beat of the burst.
- Reset asserted mid-burst: outputs drop to reset values immediately. The burst is abandoned, and no further beats follow after reset deasserts.

Decomposition:
- Shared package sgdmac_pkg holds:
  - AXI resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10)
  - burst constants (BURST_FIXED, BURST_INCR)
  - SIZE_4B=3'b010
  - DESC_WORDS=4
  - the responder state enum.
- One sub-module, sgdmac_desc_ram: 1R1W synchronous RAM, DEPTH_LOG2 parameter, write-first bypass. It is the technology swap point.

Test Plan:
- Preload idx 0..3 = 32'h1000_0000, 32'h0000_0040, 32'h0000_0001, 32'h0000_0010. AR addr=0x0, len=3, INCR, id=5, rready=1 → 4 beats in consecutive cycles with rid=5, data in order, rresp=0, rlast only on beat 4, first rvalid 2 cycles after the AR handshake.
- Same burst with rready toggling 1,0,0,1,0,1,1 → no beat lost or duplicated, and outputs are stable during stalls.
- AR addr=0x3F8 (idx 254), len=3, INCR, DEPTH_LOG2=8 → data from idx 254, 255, 0, 1.
- AR addr=0x0000_0402 (unaligned) or arsize=3'b011 or arburst=2'b10 → 4 beats with rresp=2'b10, rdata=0, rlast on beat 4, then arready returns high.
- A write of idx 1 = 32'hDEAD_BEEF in the same cycle the read-ahead targets idx 1 → beat 2 returns 32'hDEAD_BEEF.
- Assert rst_n=0 after beat 2 of a 4-beat burst → rvalid=0 and arready=0 immediately. After release: IDLE, arready=1, and no stray beats.
